// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: controller states and
// SPI mode encodings ({cpol, cpha}).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: toggles the SPI clock every CLK_DIV enabled cycles and
// flags leading/trailing edges one cycle ahead of the visible toggle.
module spi_clk_gen #(
  parameter int CLK_DIV = 4,
  parameter int TW      = 7
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          en,
  input  logic          clr,
  input  logic          cpol,
  input  logic [TW-1:0] budget,
  output logic          spi_clk,
  output logic          lead_stb,
  output logic          trail_stb,
  output logic          last_edge
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tog_cnt;
  logic          phase;
  logic          wrap;

  assign wrap = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt <= '0;
      tog_cnt <= '0;
      phase   <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      tog_cnt <= '0;
      phase   <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        div_cnt <= '0;
        phase   <= ~phase;
        tog_cnt <= tog_cnt + TW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // phase 0 means the clock sits at cpol, so the next toggle is a leading edge
  assign lead_stb  = wrap & ~phase;
  assign trail_stb = wrap & phase;
  assign last_edge = wrap && (tog_cnt == budget - TW'(1));
  assign spi_clk   = cpol ^ phase;

endmodule

// File: rtl/spi_master_ctrl_param.sv
// Parametrised SPI master: N-byte transfers, run-time CPOL/CPHA, chip-select
// setup/hold, abort and start/busy/done handshake, all on clk_i.
module spi_master_ctrl_param
  import spi_pkg::*;
#(
  parameter  int MAX_BYTES = 4,
  parameter  int CLK_DIV   = 4,
  localparam int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   cpol_i,
  input  logic                   cpha_i,
  input  logic [NB_W-1:0]        nbytes_i,
  input  logic [8*MAX_BYTES-1:0] write_data_i,
  output logic [8*MAX_BYTES-1:0] read_data_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   spi_clk_o,
  output logic                   spi_mosi_o,
  input  logic                   spi_miso_i,
  output logic                   spi_cs_n_o
);

  localparam int W  = 8 * MAX_BYTES;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = NB_W + 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            cpol_q, cpha_q;
  logic [NB_W-1:0] n_q, n_clamp;
  logic [W-1:0]    tx_sr, rx_sr, rd_q, tx_aligned;
  logic            mosi_q, done_q;
  logic            accept, finish, cnt_wrap;
  logic            lead_stb, trail_stb, last_edge;
  logic            samp_stb, shift_stb;

  assign accept   = (state_q == IDLE) && start_i && (nbytes_i != '0);
  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_comb begin
    n_clamp = (nbytes_i > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes_i;
    // left-align so the first bit to send always sits in the MSB
    tx_aligned = write_data_i << (8 * (MAX_BYTES - int'(n_clamp)));
  end

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE:     if (accept) state_d = CS_SETUP;
      CS_SETUP: if (cnt_wrap) state_d = SHIFT;
      SHIFT:    if (last_edge) state_d = CS_HOLD;
      CS_HOLD: begin
        if (cnt_wrap) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      cnt_q <= '0;
    else if (((state_q == CS_SETUP) || (state_q == CS_HOLD)) && (state_d == state_q))
      cnt_q <= cnt_q + CW'(1);
    else
      cnt_q <= '0;
  end

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .TW      (TW)
  ) u_clk_gen (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .en        (state_q == SHIFT),
    .clr       ((state_q != SHIFT) || abort_i),
    .cpol      (cpol_q),
    .budget    ({n_q, 4'b0000}),
    .spi_clk   (spi_clk_o),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_edge (last_edge)
  );

  always_comb begin
    samp_stb  = 1'b0;
    shift_stb = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0, MODE2: begin
        samp_stb  = lead_stb;
        shift_stb = trail_stb && !last_edge;
      end
      MODE1, MODE3: begin
        samp_stb  = trail_stb;
        shift_stb = lead_stb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      n_q    <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      rd_q   <= '0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) rd_q <= rx_sr;
      if (accept) begin
        cpol_q <= cpol_i;
        cpha_q <= cpha_i;
        n_q    <= n_clamp;
        rx_sr  <= '0;
        // cpha=0 presents the first bit during CS setup; cpha=1 waits for the leading edge
        if (cpha_i) begin
          tx_sr  <= tx_aligned;
          mosi_q <= 1'b0;
        end else begin
          tx_sr  <= tx_aligned << 1;
          mosi_q <= tx_aligned[W-1];
        end
      end else begin
        if (samp_stb) rx_sr <= {rx_sr[W-2:0], spi_miso_i};
        if (shift_stb) begin
          mosi_q <= tx_sr[W-1];
          tx_sr  <= tx_sr << 1;
        end
      end
    end
  end

  assign read_data_o = rd_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign spi_cs_n_o  = (state_q == IDLE);
  assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl_param.sv
// Self-checking bench for spi_master_ctrl_param: directed and random transfers
// checked against a slave/bit-stream model and closed-form latency.
`define CHECK(TAG, OBS, EXP) \
  begin \
    tests++; \
    assert ((OBS) === (EXP)) else begin \
      fails++; \
      $error("FAIL %s: observed %0h, expected %0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_spi_master_ctrl_param;

  localparam int MAXB = 4;
  localparam int DIV  = 4;
  localparam int NBW  = $clog2(MAXB + 1);
  localparam int W    = 8 * MAXB;

  logic           clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic           cpol = 1'b0, cpha = 1'b0;
  logic [NBW-1:0] nbytes = '0;
  logic [W-1:0]   wdata = '0;
  logic [W-1:0]   rdata;
  logic           done, busy, sclk, mosi, miso, cs_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_param #(
    .MAX_BYTES (MAXB),
    .CLK_DIV   (DIV)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .abort_i      (abort),
    .cpol_i       (cpol),
    .cpha_i       (cpha),
    .nbytes_i     (nbytes),
    .write_data_i (wdata),
    .read_data_o  (rdata),
    .done_o       (done),
    .busy_o       (busy),
    .spi_clk_o    (sclk),
    .spi_mosi_o   (mosi),
    .spi_miso_i   (miso),
    .spi_cs_n_o   (cs_n)
  );

  // Slave / bus monitor state (written only by the monitor, except the m_* config)
  logic         mon_clr = 1'b0, loop_en = 1'b1, slave_miso = 1'b0;
  logic         m_cpol = 1'b0, m_cpha = 1'b0;
  int           m_n = 1;
  logic [W-1:0] slave_word = '0;
  int           s_idx = 0, lead_cnt = 0, trail_cnt = 0, mosi_viol = 0, done_cnt = 0;
  bit           mosi_bits[$];
  logic         prev_clk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  logic         e_any, e_lead, e_trail, e_samp, e_shf;

  assign miso = loop_en ? mosi : slave_miso;

  always @(negedge clk) begin
    if (mon_clr) begin
      lead_cnt = 0; trail_cnt = 0; mosi_viol = 0; done_cnt = 0; s_idx = 0;
      mosi_bits.delete();
    end else begin
      if (done) done_cnt++;
      if (!cs_n && prev_cs) begin
        s_idx = 0;
        if (!m_cpha) begin
          slave_miso = slave_word[8*m_n-1];
          s_idx = 1;
        end
      end else if (!cs_n && !prev_cs) begin
        e_any   = (sclk != prev_clk);
        e_lead  = e_any && (sclk != m_cpol);
        e_trail = e_any && (sclk == m_cpol);
        e_samp  = m_cpha ? e_trail : e_lead;
        e_shf   = m_cpha ? e_lead : e_trail;
        if (e_lead) lead_cnt++;
        if (e_trail) trail_cnt++;
        if (e_samp) mosi_bits.push_back(mosi);
        if (e_shf && s_idx < 8*m_n) begin
          slave_miso = slave_word[8*m_n-1-s_idx];
          s_idx++;
        end
        if ((mosi != prev_mosi) && !e_shf) mosi_viol++;
      end
    end
    prev_clk  = sclk;
    prev_cs   = cs_n;
    prev_mosi = mosi;
  end

  function automatic logic [W-1:0] low_bytes(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8*n; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic run_txn(input logic pol, input logic pha, input int nb_req,
                         input logic [W-1:0] wd, input logic lp, input logic [W-1:0] sw,
                         input logic poke, output logic [W-1:0] exp_rx);
    int n, exp_lat, k, busy_bad;
    logic [W-1:0] got;
    n       = (nb_req > MAXB) ? MAXB : nb_req;
    exp_lat = (16*n + 2) * DIV + 1;
    exp_rx  = lp ? low_bytes(wd, n) : low_bytes(sw, n);
    @(posedge clk); #1;
    mon_clr = 1'b1; m_cpol = pol; m_cpha = pha; m_n = n; loop_en = lp; slave_word = sw;
    cpol = pol; cpha = pha; nbytes = NBW'(nb_req); wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; start = 1'b0;
    cpol = ~pol; cpha = ~pha; nbytes = NBW'($urandom_range(1, MAXB)); wdata = W'($urandom());
    `CHECK("setup_clk_idle", sclk, pol)
    k = 1; busy_bad = 0;
    while (!done && k < exp_lat + 20) begin
      if (!busy) busy_bad++;
      start = (poke && k == exp_lat / 2);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    `CHECK("done_latency", k, exp_lat)
    `CHECK("busy_during", busy_bad, 0)
    `CHECK("busy_at_done", busy, 1'b0)
    `CHECK("read_data", rdata, exp_rx)
    @(posedge clk); #1;
    `CHECK("done_one_cycle", done, 1'b0)
    `CHECK("cs_released", cs_n, 1'b1)
    `CHECK("clk_idle_after", sclk, pol)
    `CHECK("mosi_bit_count", mosi_bits.size(), 8*n)
    got = '0;
    foreach (mosi_bits[i]) got = {got[W-2:0], mosi_bits[i]};
    `CHECK("mosi_stream", got, low_bytes(wd, n))
    `CHECK("mosi_edge_only", mosi_viol, 0)
    `CHECK("lead_edges", lead_cnt, 8*n)
    `CHECK("trail_edges", trail_cnt, 8*n)
    `CHECK("done_pulses", done_cnt, 1)
    if (poke) begin
      busy_bad = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (busy) busy_bad++;
      end
      `CHECK("poke_no_restart", busy_bad, 0)
    end
  endtask

  initial begin
    logic [W-1:0] last_exp, tmp_exp;
    logic [7:0]   first_byte;
    int           k, bad;

    repeat (3) @(posedge clk);
    #1;
    `CHECK("rst_cs_n", cs_n, 1'b1)
    `CHECK("rst_clk", sclk, 1'b0)
    `CHECK("rst_mosi", mosi, 1'b0)
    `CHECK("rst_busy", busy, 1'b0)
    `CHECK("rst_done", done, 1'b0)
    `CHECK("rst_rdata", rdata, '0)
    @(negedge clk); rstn = 1'b1;

    run_txn(1'b0, 1'b0, 1, 32'h000000A5, 1'b1, '0, 1'b0, last_exp);
    `CHECK("m0_a5", last_exp, 32'h000000A5)

    run_txn(1'b1, 1'b1, 4, 32'h12345678, 1'b0, 32'hCAFEBABE, 1'b0, last_exp);
    first_byte = '0;
    for (int i = 0; i < 8; i++) first_byte = {first_byte[6:0], mosi_bits[i]};
    `CHECK("m3_first_byte", first_byte, 8'h12)

    run_txn(1'b0, 1'b1, 2, 32'h0000BEEF, 1'b1, '0, 1'b0, last_exp);
    run_txn(1'b1, 1'b0, 2, 32'h0000BEEF, 1'b1, '0, 1'b0, last_exp);

    // start and abort together in IDLE: start wins; then abort mid byte 2
    @(posedge clk); #1;
    mon_clr = 1'b1; m_cpol = 1'b1; m_cpha = 1'b0; m_n = 3; loop_en = 1'b1;
    cpol = 1'b1; cpha = 1'b0; nbytes = NBW'(3); wdata = W'($urandom()); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; start = 1'b0; abort = 1'b0;
    `CHECK("start_beats_abort", busy, 1'b1)
    k = 0;
    while (mosi_bits.size() < 12 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    `CHECK("abort_reached_byte2", (k < 2000), 1'b1)
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    `CHECK("abort_cs", cs_n, 1'b1)
    `CHECK("abort_clk", sclk, 1'b1)
    `CHECK("abort_busy", busy, 1'b0)
    repeat (300) @(posedge clk);
    #1;
    `CHECK("abort_no_done", done_cnt, 0)
    `CHECK("abort_rdata_held", rdata, last_exp)

    // zero-length start is ignored
    @(posedge clk); #1;
    mon_clr = 1'b1; nbytes = '0; start = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; start = 1'b0;
    bad = 0;
    repeat (60) begin
      if (busy || !cs_n) bad++;
      @(posedge clk); #1;
    end
    `CHECK("zero_len_idle", bad, 0)
    `CHECK("zero_len_no_done", done_cnt, 0)

    run_txn(1'b0, 1'b1, 7, W'($urandom()), 1'b0, W'($urandom()), 1'b0, last_exp);
    run_txn(1'b1, 1'b1, 3, W'($urandom()), 1'b1, '0, 1'b1, last_exp);

    for (int t = 0; t < 6; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, MAXB),
              W'($urandom()), 1'($urandom_range(0, 1)), W'($urandom()), 1'b0, tmp_exp);
      last_exp = tmp_exp;
    end

    // reset mid-SHIFT must drop everything asynchronously
    @(posedge clk); #1;
    mon_clr = 1'b1; m_cpol = 1'b1; m_cpha = 1'b1; m_n = 2; loop_en = 1'b1;
    cpol = 1'b1; cpha = 1'b1; nbytes = NBW'(2); wdata = W'($urandom()); start = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; start = 1'b0;
    repeat (DIV + 30) @(posedge clk);
    #1;
    `CHECK("pre_reset_busy", busy, 1'b1)
    rstn = 1'b0;
    #1;
    `CHECK("mid_rst_cs_n", cs_n, 1'b1)
    `CHECK("mid_rst_clk", sclk, 1'b0)
    `CHECK("mid_rst_mosi", mosi, 1'b0)
    `CHECK("mid_rst_busy", busy, 1'b0)
    `CHECK("mid_rst_done", done, 1'b0)
    `CHECK("mid_rst_rdata", rdata, '0)
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
